// File: rtl/fp_div_iter.sv
// Iterative IEEE-754 single-precision divider: restoring mantissa division, one quotient
// bit per cycle, denormals flushed to zero, round toward zero, specials resolved at accept.
module fp_div_iter #(
   parameter int unsigned QBITS = 25
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result,
   output logic        busy,
   output logic        done,
   output logic        dz,
   output logic        nv
);

   localparam int unsigned CNT_W = $clog2(QBITS);
   localparam logic [31:0] QNAN  = 32'h7FC0_0000;

   typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

   state_t             state_q, state_d;
   logic [31:0]        result_q, result_d;
   logic               dz_q, dz_d, nv_q, nv_d;
   logic               sign_q, sign_d;
   logic [7:0]         ea_q, ea_d, eb_q, eb_d;
   logic [23:0]        mb_q, mb_d;
   logic [24:0]        rem_q, rem_d;
   logic [QBITS-1:0]   q_q, q_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, s_in;
   logic               qbit;
   logic [24:0]        rem_sub;
   logic [9:0]         exp_w;

   always_comb begin
      a_zero = (a[30:23] == 8'd0);
      b_zero = (b[30:23] == 8'd0);
      a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      s_in   = a[31] ^ b[31];
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      dz_d     = dz_q;
      nv_d     = nv_q;
      sign_d   = sign_q;
      ea_d     = ea_q;
      eb_d     = eb_q;
      mb_d     = mb_q;
      rem_d    = rem_q;
      q_d      = q_q;
      cnt_d    = cnt_q;
      qbit     = (rem_q >= {1'b0, mb_q});
      rem_sub  = qbit ? (rem_q - {1'b0, mb_q}) : rem_q;
      // ea-eb plus bias, one less when the quotient mantissa lands below 1.0
      exp_w    = {2'b00, ea_q} - {2'b00, eb_q} + (q_q[QBITS-1] ? 10'd127 : 10'd126);

      unique case (state_q)
         IDLE: begin
            if (start) begin
               dz_d   = 1'b0;
               nv_d   = 1'b0;
               sign_d = s_in;
               ea_d   = a[30:23];
               eb_d   = b[30:23];
               mb_d   = {1'b1, b[22:0]};
               rem_d  = {2'b01, a[22:0]};
               q_d    = '0;
               cnt_d  = CNT_W'(QBITS - 1);
               state_d = DONE;
               if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
                  result_d = QNAN;
                  nv_d     = 1'b1;
               end else if (a_inf) begin
                  result_d = {s_in, 8'hFF, 23'd0};
               end else if (b_zero) begin
                  result_d = {s_in, 8'hFF, 23'd0};
                  dz_d     = 1'b1;
               end else if (a_zero || b_inf) begin
                  result_d = {s_in, 31'd0};
               end else begin
                  state_d = DIV;
               end
            end
         end
         DIV: begin
            q_d   = {q_q[QBITS-2:0], qbit};
            // rem_sub < mb < 2^24 here, so the dropped top bit is always zero
            rem_d = {rem_sub[23:0], 1'b0};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d = NORM;
            end
         end
         NORM: begin
            if ($signed(exp_w) >= $signed(10'sd255)) begin
               result_d = {sign_q, 8'hFF, 23'd0};
            end else if ($signed(exp_w) <= $signed(10'sd0)) begin
               result_d = {sign_q, 31'd0};
            end else if (q_q[QBITS-1]) begin
               result_d = {sign_q, exp_w[7:0], q_q[23:1]};
            end else begin
               result_d = {sign_q, exp_w[7:0], q_q[22:0]};
            end
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         result_q <= '0;
         dz_q     <= 1'b0;
         nv_q     <= 1'b0;
         sign_q   <= 1'b0;
         ea_q     <= '0;
         eb_q     <= '0;
         mb_q     <= '0;
         rem_q    <= '0;
         q_q      <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         dz_q     <= dz_d;
         nv_q     <= nv_d;
         sign_q   <= sign_d;
         ea_q     <= ea_d;
         eb_q     <= eb_d;
         mb_q     <= mb_d;
         rem_q    <= rem_d;
         q_q      <= q_d;
         cnt_q    <= cnt_d;
      end
   end

   assign result = result_q;
   assign dz     = dz_q;
   assign nv     = nv_q;
   assign busy   = (state_q != IDLE);
   assign done   = (state_q == DONE);

endmodule

// File: tb/tb_fp_div_iter.sv
// Directed bench for fp_div_iter: hand-computed quotients, specials, latency,
// ignored start during DIV, and asynchronous reset mid-division.
module tb_fp_div_iter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [31:0] result;
   logic        busy, done, dz, nv;

   int unsigned n_pass = 0;
   int unsigned n_total = 0;

   fp_div_iter #(.QBITS(25)) dut (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
      .result(result), .busy(busy), .done(done), .dz(dz), .nv(nv)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
   endtask

   // One complete operation; operand inputs are scrambled right after acceptance.
   task automatic run_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                         input logic [31:0] er, input logic edz, input logic env,
                         input int lat);
      int cyc;
      logic busy_ok;
      @(negedge clk);
      a = ia; b = ib; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a = $urandom; b = $urandom;
      check({tag, " dz_clear_at_accept"}, {31'd0, dz}, {31'd0, (lat == 0) ? edz : 1'b0});
      check({tag, " nv_clear_at_accept"}, {31'd0, nv}, {31'd0, (lat == 0) ? env : 1'b0});
      cyc = 0;
      busy_ok = 1'b1;
      while (done !== 1'b1 && cyc < 40) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         @(posedge clk);
         #1;
         cyc++;
      end
      check({tag, " latency"}, cyc, lat);
      check({tag, " busy_held"}, {31'd0, busy_ok}, 32'd1);
      check({tag, " busy_in_done"}, {31'd0, busy}, 32'd1);
      check({tag, " result"}, result, er);
      check({tag, " dz"}, {31'd0, dz}, {31'd0, edz});
      check({tag, " nv"}, {31'd0, nv}, {31'd0, env});
      @(posedge clk);
      #1;
      check({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
      check({tag, " idle_busy"}, {31'd0, busy}, 32'd0);
      check({tag, " result_held"}, result, er);
   endtask

   initial begin
      int cyc;
      #2;
      check("reset result", result, 32'd0);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset dz", {31'd0, dz}, 32'd0);
      check("reset nv", {31'd0, nv}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      run_op("6/2",        32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 26);
      run_op("1/3",        32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 1'b0, 26);
      run_op("-6/2",       32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 1'b0, 26);
      run_op("-1/0",       32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 1'b0, 0);
      run_op("0/0",        32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b1, 0);
      run_op("nan/1",      32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b1, 0);
      run_op("overflow",   32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0, 1'b0, 26);
      run_op("underflow",  32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 26);
      run_op("denorm/1",   32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 0);

      // start pulsed 5 cycles into DIV with other operands must be ignored
      @(negedge clk);
      a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc = 0;
      while (done !== 1'b1 && cyc < 40) begin
         if (cyc == 5) begin
            @(negedge clk);
            a = 32'h3F800000; b = 32'h00000000; start = 1'b1;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         cyc++;
      end
      check("ignore latency", cyc, 26);
      check("ignore result", result, 32'h40400000);
      check("ignore dz", {31'd0, dz}, 32'd0);
      @(posedge clk);
      #1;

      // dz from the prior op must clear when the next start is accepted
      run_op("-1/0 again", 32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 1'b0, 0);
      run_op("1/3 after dz", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 1'b0, 26);
      run_op("0/0 again",  32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b1, 0);

      // asynchronous reset 10 cycles into DIV
      @(negedge clk);
      a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      check("pre-reset busy", {31'd0, busy}, 32'd1);
      check("pre-reset result", result, 32'h7FC00000);
      reset = 1'b1;
      #1;
      check("async reset busy", {31'd0, busy}, 32'd0);
      check("async reset done", {31'd0, done}, 32'd0);
      check("async reset result", result, 32'd0);
      check("async reset dz", {31'd0, dz}, 32'd0);
      check("async reset nv", {31'd0, nv}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run_op("6/2 after reset", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 26);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fp_div_iter.md
Name: fp_div_iter

Overview:
- Iterative IEEE-754 single-precision divider; the inverse-operation counterpart of the datapath's combinational FP multiplier.
- Computes a / b over multiple cycles using a restoring mantissa division, one quotient bit per cycle.
- Sits beside the ALU. The control unit stalls on busy and captures result on done.
- Simplified FP model, matching the datapath's FP units: denormals flushed to zero, round toward zero, no exception traps.

Parameters:
- QBITS, 25, number of quotient bits produced (one per DIV cycle); fixed for single precision.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  32  dividend, IEEE-754 single
- b  input  32  divisor, IEEE-754 single
- result  output  32  quotient; held until next result write
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse; result/dz/nv valid
- dz  output  1  divide-by-zero flag, held with result
- nv  output  1  invalid-operation flag, held with result

Behaviour:
- Reset (async, any state): state=IDLE, result=0, done=0, busy=0, dz=0, nv=0, counter/remainder/quotient cleared.
- States: IDLE, DIV, NORM, DONE.
- Accepting a request (edge T0, IDLE with start=1):
  - Latch the operands.
  - Clear dz and nv.
  - Classify the operands:
    - exp==0 → zero (denormals included).
    - exp==255, frac==0 → inf.
    - exp==255, frac!=0 → NaN.
- Specials, first match wins (result written at T0, state→DONE):
  - Either operand NaN → 0x7FC00000, nv=1.
  - inf/inf or 0/0 → 0x7FC00000, nv=1.
  - a inf → signed inf.
  - b zero → signed inf, dz=1.
  - a zero or b inf → signed zero.
  - Sign of a signed result = a[31]^b[31].
- Normal path (T0 → DIV):
  - ma={1,fa}, mb={1,fb} (24b).
  - Remainder initialised to ma; counter=QBITS-1.
- DIV, each edge produces one quotient bit, MSB first:
  - If rem>=mb: bit=1, rem=rem-mb; else bit=0.
  - Then rem<<=1.
  - After QBITS edges (T1..T25) → NORM.
  - Resulting q = floor(ma·2^24/mb), 25 bits, q[24] or q[23] set.
- NORM (edge T26): write result, state→DONE.
  - Mantissa and exponent:
    - If q[24]=1: mant=q[23:1], e=ea-eb+127.
    - Else: mant=q[22:0], e=ea-eb+126.
  - e is computed as a 10-bit signed value.
  - e>=255 → signed inf (no flag).
  - e<=0 → signed zero.
  - Otherwise → {sign, e[7:0], mant}.
  - Truncation only; no rounding.
- DONE:
  - done=1 for exactly one cycle, busy=1.
  - Next edge → IDLE.
- Latency from the start edge:
  - Normal: done high in the cycle after edge T0+26.
  - Special: done high in the cycle after edge T0.
- start is ignored in DIV, NORM and DONE. A new request is accepted only in IDLE, so back-to-back requests need start held into IDLE.
- Operand inputs may change after T0 without effect.
- result, dz and nv are held stable from their write until the next accepted start or reset.

Test Plan:
- 0x40C00000 / 0x40000000 (6/2) → result=0x40400000, dz=nv=0. done pulses exactly once, in the cycle after edge T0+26; busy high from T0 through DONE.
- 0x3F800000 / 0x40400000 (1/3) → 0x3EAAAAAA (truncated, not 0x3EAAAAAB). Also check 0xC0C00000 / 0x40000000 → 0xC0400000.
- 0xBF800000 / 0x00000000 → 0xFF800000, dz=1, done one cycle after start edge. 0x00000000 / 0x00000000 → 0x7FC00000, nv=1, dz=0. 0x7FC00001 / 0x3F800000 → 0x7FC00000, nv=1.
- 0x7F000000 / 0x3E800000 → 0x7F800000 (overflow). 0x00800000 / 0x40000000 → 0x00000000 (underflow). 0x00000001 (denormal) / 0x3F800000 → 0x00000000.
- Pulse start again at cycle 5 of DIV with different operands → ignored; first result unchanged. A start presented in IDLE afterwards is accepted, and dz/nv from the prior op are cleared at acceptance.
- Assert reset 10 cycles into DIV → busy, done, result, dz and nv go to 0 immediately without a clock edge. After release, a new 6/2 request completes normally with 0x40400000.
